serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// serial_adder: bit-serial WIDTH-bit adder built around one fulladder slice,
// LSB first, parallel result with a one-cycle done pulse.

module fulladder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_w;
    logic             cnext_w;
    logic [WIDTH-1:0] s_next_w;

    fulladder u_fa (
        .x (a_sr_q[0]),
        .y (b_sr_q[0]),
        .z (carry_q),
        .s (bit_w),
        .c (cnext_w)
    );

    // Only the upper WIDTH-1 partial-sum bits need storage; the newest bit
    // comes straight from the adder slice.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_next_w = bit_w;
        end else begin : g_wn
            logic [WIDTH-2:0] s_sr_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_sr_q <= '0;
                end else if (state_q == S_SHIFT) begin
                    s_sr_q <= s_next_w[WIDTH-1:1];
                end
            end

            assign s_next_w = {bit_w, s_sr_q};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = cnext_w;
                cnt_d   = cnt_q + CNT_W'(1);
                busy_d  = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = s_next_w;
                    cout_d  = cnext_w;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE accept a new start identically.
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// tb_serial_adder: directed checks of the WIDTH=8 adder plus randomized
// checks of WIDTH=1 and WIDTH=16 instances against a+b+cin.

module tb_serial_adder;
    logic clk;
    logic rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start1, cin1, busy1, done1, cout1;
    logic [0:0]  a1, b1, sum1;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    int n_tests;
    int n_fail;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1),
        .cin_i(cin1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
    );
    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16),
        .cin_i(cin16), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One add on the WIDTH=8 instance; returns result and edges-to-done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int lat);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done8) begin
                lat = k;
                break;
            end
        end
        s = sum8; co = cout8;
    endtask

    task automatic run_w(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output logic [15:0] s, output logic co,
                         output int lat);
        if (w == 1) begin
            a1 = a[0:0]; b1 = b[0:0]; cin1 = c; start1 = 1'b1;
        end else begin
            a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        end
        tick();
        start1 = 1'b0; start16 = 1'b0;
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if ((w == 1) ? done1 : done16) begin
                lat = k;
                break;
            end
        end
        if (w == 1) begin
            s = {15'd0, sum1}; co = cout1;
        end else begin
            s = sum16; co = cout16;
        end
    endtask

    initial begin
        logic [7:0]  s;
        logic        co;
        int          lat;
        int          dones;
        int          d1, d2;
        logic [15:0] ra, rb, rs, msk;
        logic        rc, rco;
        logic [16:0] full;

        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        start16 = 0; a16 = 0; b16 = 0; cin16 = 0;

        // Reset state
        repeat (3) tick();
        check("rst_sum", sum8, 8'h00);
        check("rst_cout", cout8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic add and done pulse width
        run8(8'h5A, 8'h3C, 1'b0, s, co, lat);
        check("basic_lat", lat, 8);
        check("basic_sum", s, 8'h96);
        check("basic_cout", co, 1'b0);
        check("basic_busy_in_done", busy8, 1'b1);
        tick();
        check("basic_done_1cyc", done8, 1'b0);
        check("basic_busy_fall", busy8, 1'b0);
        check("hold_idle_sum", sum8, 8'h96);

        // Carry ripple
        run8(8'hFF, 8'h01, 1'b0, s, co, lat);
        check("ripple1_sum", s, 8'h00);
        check("ripple1_cout", co, 1'b1);
        tick();
        run8(8'hFF, 8'hFF, 1'b1, s, co, lat);
        check("ripple2_sum", s, 8'hFF);
        check("ripple2_cout", co, 1'b1);
        tick();

        // Start ignored during SHIFT; operands may change after capture
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        dones = 0; d1 = 0;
        for (int k = 1; k <= 20; k++) begin
            a8 = 8'(k * 37); b8 = 8'(k * 91); cin8 = k[0];
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            tick();
            if (done8) begin
                dones++;
                if (d1 == 0) d1 = k;
            end
        end
        check("ign_dones", dones, 1);
        check("ign_lat", d1, 8);
        check("ign_sum", sum8, 8'h30);
        check("ign_cout", cout8, 1'b0);

        // Mid-operation reset
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_sum", sum8, 8'h00);
        check("mrst_busy", busy8, 1'b0);
        check("mrst_done", done8, 1'b0);
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8) dones++;
        end
        check("mrst_no_done", dones, 0);
        run8(8'h01, 8'h02, 1'b0, s, co, lat);
        check("mrst_after_sum", s, 8'h03);
        check("mrst_after_lat", lat, 8);
        tick();

        // Back-to-back with start held high
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1;
        d1 = 0; d2 = 0; dones = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 9) start8 = 1'b0;
            if (!busy8) dones = dones + 100;
            if (done8) begin
                if (d1 == 0) begin
                    d1 = k;
                    check("b2b_sum1", sum8, 8'h00);
                    check("b2b_cout1", cout8, 1'b1);
                end else begin
                    d2 = k;
                end
            end
            if (k == 12) check("b2b_hold", {cout8, sum8}, 9'h100);
        end
        check("b2b_busy_low", dones, 0);
        check("b2b_gap", d2 - d1, 9);
        check("b2b_sum2", sum8, 8'h81);
        check("b2b_cout2", cout8, 1'b0);
        tick();
        tick();
        check("b2b_idle", busy8, 1'b0);

        // Random: WIDTH=1 then WIDTH=16
        for (int w = 1; w <= 16; w += 15) begin
            msk = (w == 1) ? 16'h0001 : 16'hFFFF;
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom) & msk;
                rb = 16'($urandom) & msk;
                rc = 1'($urandom);
                run_w(w, ra, rb, rc, rs, rco, lat);
                full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
                if (w == 1) begin
                    check("rnd1_sum", rs, {15'd0, full[0]});
                    check("rnd1_cout", rco, full[1]);
                end else begin
                    check("rnd16_sum", rs, full[15:0]);
                    check("rnd16_cout", rco, full[16]);
                end
                check("rnd_lat", lat, w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
